// File: rtl/inst_fetch.sv
// Dual-issue instruction fetch: one 64-bit pair per memory request, one request
// outstanding, offers up to two instructions to the instruction buffer.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   input  logic        instbuf_full,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [63:0] imem_rdata,
   output logic [1:0]  issue,
   output logic [31:0] in1_inst,
   output logic [31:0] in1_pc,
   output logic [31:0] in1_npc,
   output logic [31:0] in2_inst,
   output logic [31:0] in2_pc,
   output logic [31:0] in2_npc
);

   typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [1:0]  issue_nxt;
   logic [31:0] in1_inst_nxt, in1_pc_nxt, in1_npc_nxt;
   logic [31:0] in2_inst_nxt, in2_pc_nxt, in2_npc_nxt;
   logic        req_outstanding;

   function automatic logic [31:0] pair_base(input logic [31:0] a);
      return {a[31:3], 3'b000};
   endfunction

   function automatic logic [31:0] next_pair(input logic [31:0] a);
      return {a[31:3] + 29'd1, 3'b000};
   endfunction

   assign imem_req  = (state == REQ);
   assign imem_addr = pair_base(pc);

   // A request is still in flight after this edge if it was granted now, or
   // was granted earlier and its data has not yet returned.
   assign req_outstanding = ((state == REQ)  && imem_gnt)     ||
                            ((state == WAIT) && !imem_rvalid) ||
                            ((state == DROP) && !imem_rvalid);

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      issue_nxt    = issue;
      in1_inst_nxt = in1_inst;
      in1_pc_nxt   = in1_pc;
      in1_npc_nxt  = in1_npc;
      in2_inst_nxt = in2_inst;
      in2_pc_nxt   = in2_pc;
      in2_npc_nxt  = in2_npc;

      if (branch_flag) begin
         pc_nxt    = branch_target;
         issue_nxt = 2'b00;
         state_nxt = req_outstanding ? DROP : REQ;
      end else begin
         case (state)
            REQ: begin
               if (imem_gnt)
                  state_nxt = WAIT;
            end
            WAIT: begin
               if (imem_rvalid) begin
                  state_nxt = HOLD;
                  pc_nxt    = next_pair(pc);
                  // An odd-word pc (e.g. a branch target) only uses the upper word.
                  if (!pc[2]) begin
                     issue_nxt    = 2'b11;
                     in1_inst_nxt = imem_rdata[31:0];
                     in1_pc_nxt   = pc;
                     in1_npc_nxt  = pc + 32'd4;
                     in2_inst_nxt = imem_rdata[63:32];
                     in2_pc_nxt   = pc + 32'd4;
                     in2_npc_nxt  = pc + 32'd8;
                  end else begin
                     issue_nxt    = 2'b10;
                     in1_inst_nxt = imem_rdata[63:32];
                     in1_pc_nxt   = pc;
                     in1_npc_nxt  = pc + 32'd4;
                     in2_inst_nxt = 32'd0;
                     in2_pc_nxt   = 32'd0;
                     in2_npc_nxt  = 32'd0;
                  end
               end
            end
            HOLD: begin
               if ((issue != 2'b00) && !instbuf_full) begin
                  issue_nxt = 2'b00;
                  state_nxt = REQ;
               end
            end
            DROP: begin
               if (imem_rvalid)
                  state_nxt = REQ;
            end
            default: state_nxt = REQ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= REQ;
         pc       <= RESET_PC;
         issue    <= 2'b00;
         in1_inst <= 32'd0;
         in1_pc   <= 32'd0;
         in1_npc  <= 32'd0;
         in2_inst <= 32'd0;
         in2_pc   <= 32'd0;
         in2_npc  <= 32'd0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         issue    <= issue_nxt;
         in1_inst <= in1_inst_nxt;
         in1_pc   <= in1_pc_nxt;
         in1_npc  <= in1_npc_nxt;
         in2_inst <= in2_inst_nxt;
         in2_pc   <= in2_pc_nxt;
         in2_npc  <= in2_npc_nxt;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Table-driven bench for inst_fetch: per-cycle input/expected-output vectors
// plus a few hand-written redirect and timing sequences.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        instbuf_full = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [63:0] imem_rdata = 64'd0;
   logic [1:0]  issue;
   logic [31:0] in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc;

   int checks = 0;
   int passed = 0;

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .branch_flag(branch_flag), .branch_target(branch_target),
      .instbuf_full(instbuf_full), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .issue(issue), .in1_inst(in1_inst), .in1_pc(in1_pc), .in1_npc(in1_npc),
      .in2_inst(in2_inst), .in2_pc(in2_pc), .in2_npc(in2_npc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, bf;
      logic [31:0] tgt;
      logic        full, gnt, rv;
      logic [63:0] rdata;
      logic        req;
      logic [31:0] addr;
      logic [1:0]  iss;
      logic [31:0] i1pc, i1npc, i1inst, i2pc, i2npc, i2inst;
   } vec_t;

   localparam logic [63:0] D1 = 64'h00208093_00100093;
   localparam logic [63:0] D2 = 64'hAAAAAAAA_55555555;
   localparam logic [63:0] D3 = 64'h11111111_22222222;
   localparam logic [63:0] DX = 64'hDEADBEEF_CAFEF00D;

   // Offer sets: 0 = all zero, 1 = pair at 0, 2 = single at 0x104, 3 = pair at 0x200
   function automatic vec_t mk(input logic r, input logic bf, input logic [31:0] tgt,
                               input logic full, input logic gnt, input logic rv,
                               input logic [63:0] rd, input logic req,
                               input logic [31:0] addr, input logic [1:0] iss, input int set);
      vec_t v;
      v.rst = r; v.bf = bf; v.tgt = tgt; v.full = full; v.gnt = gnt; v.rv = rv;
      v.rdata = rd; v.req = req; v.addr = addr; v.iss = iss;
      v.i1pc = 0; v.i1npc = 0; v.i1inst = 0; v.i2pc = 0; v.i2npc = 0; v.i2inst = 0;
      case (set)
         1: begin
            v.i1pc = 32'h0;   v.i1npc = 32'h4;   v.i1inst = 32'h00100093;
            v.i2pc = 32'h4;   v.i2npc = 32'h8;   v.i2inst = 32'h00208093;
         end
         2: begin
            v.i1pc = 32'h104; v.i1npc = 32'h108; v.i1inst = 32'hAAAAAAAA;
         end
         3: begin
            v.i1pc = 32'h200; v.i1npc = 32'h204; v.i1inst = 32'h22222222;
            v.i2pc = 32'h204; v.i2npc = 32'h208; v.i2inst = 32'h11111111;
         end
         default: ;
      endcase
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      else
         passed++;
   endtask

   vec_t vt[$];

   initial begin
      int n;
      //            rst bf tgt      full gnt rv rdata req addr    iss   set
      vt.push_back(mk(1, 0, 32'h0,   0,  0,  0, 0,    1,  32'h0,   2'b00, 0)); // v0 reset
      vt.push_back(mk(0, 0, 32'h0,   0,  1,  0, 0,    1,  32'h0,   2'b00, 0)); // v1 grant
      vt.push_back(mk(0, 0, 32'h0,   0,  0,  1, D1,   0,  32'h0,   2'b00, 0)); // v2 data
      for (int k = 0; k < 5; k++)
         vt.push_back(mk(0, 0, 32'h0, 1,  0,  0, 0,    0,  32'h8,   2'b11, 1)); // v3-v7 full
      vt.push_back(mk(0, 0, 32'h0,   0,  0,  0, 0,    0,  32'h8,   2'b11, 1)); // v8 accept
      vt.push_back(mk(0, 1, 32'h104, 0,  0,  0, 0,    1,  32'h8,   2'b00, 1)); // v9 redirect
      vt.push_back(mk(0, 0, 32'h0,   0,  1,  0, 0,    1,  32'h100, 2'b00, 1)); // v10
      vt.push_back(mk(0, 0, 32'h0,   0,  0,  1, D2,   0,  32'h100, 2'b00, 1)); // v11
      vt.push_back(mk(0, 0, 32'h0,   0,  0,  0, 0,    0,  32'h108, 2'b10, 2)); // v12 single
      vt.push_back(mk(0, 0, 32'h0,   0,  1,  0, 0,    1,  32'h108, 2'b00, 2)); // v13
      vt.push_back(mk(0, 1, 32'h200, 0,  0,  0, 0,    0,  32'h108, 2'b00, 2)); // v14 flag in WAIT
      vt.push_back(mk(0, 0, 32'h0,   0,  0,  0, 0,    0,  32'h200, 2'b00, 2)); // v15 DROP
      vt.push_back(mk(0, 0, 32'h0,   0,  0,  1, DX,   0,  32'h200, 2'b00, 2)); // v16 orphan
      vt.push_back(mk(0, 0, 32'h0,   0,  1,  0, 0,    1,  32'h200, 2'b00, 2)); // v17
      vt.push_back(mk(0, 0, 32'h0,   0,  0,  1, D3,   0,  32'h200, 2'b00, 2)); // v18
      vt.push_back(mk(0, 1, 32'h300, 0,  0,  0, 0,    0,  32'h208, 2'b11, 3)); // v19 flag in HOLD
      vt.push_back(mk(0, 0, 32'h0,   0,  1,  0, 0,    1,  32'h300, 2'b00, 3)); // v20
      vt.push_back(mk(1, 0, 32'h0,   0,  0,  0, 0,    1,  32'h0,   2'b00, 0)); // v21 rst mid-WAIT
      vt.push_back(mk(0, 0, 32'h0,   0,  0,  1, DX,   1,  32'h0,   2'b00, 0)); // v22 stale rvalid
      vt.push_back(mk(0, 0, 32'h0,   0,  1,  0, 0,    1,  32'h0,   2'b00, 0)); // v23
      vt.push_back(mk(0, 0, 32'h0,   0,  0,  1, D1,   0,  32'h0,   2'b00, 0)); // v24
      vt.push_back(mk(0, 0, 32'h0,   1,  0,  0, 0,    0,  32'h8,   2'b11, 1)); // v25

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         rst = vt[i].rst; branch_flag = vt[i].bf; branch_target = vt[i].tgt;
         instbuf_full = vt[i].full; imem_gnt = vt[i].gnt; imem_rvalid = vt[i].rv;
         imem_rdata = vt[i].rdata;
         #1;
         chk($sformatf("v%0d.req", i),    {31'd0, imem_req}, {31'd0, vt[i].req});
         chk($sformatf("v%0d.addr", i),   imem_addr,         vt[i].addr);
         chk($sformatf("v%0d.issue", i),  {30'd0, issue},    {30'd0, vt[i].iss});
         chk($sformatf("v%0d.in1_pc", i),   in1_pc,   vt[i].i1pc);
         chk($sformatf("v%0d.in1_npc", i),  in1_npc,  vt[i].i1npc);
         chk($sformatf("v%0d.in1_inst", i), in1_inst, vt[i].i1inst);
         chk($sformatf("v%0d.in2_pc", i),   in2_pc,   vt[i].i2pc);
         chk($sformatf("v%0d.in2_npc", i),  in2_npc,  vt[i].i2npc);
         chk($sformatf("v%0d.in2_inst", i), in2_inst, vt[i].i2inst);
      end

      // Redirect in the same cycle as a grant: the grant belongs to the old
      // address, so the fetch must drain that response before re-requesting.
      @(negedge clk);
      rst = 1; instbuf_full = 0; imem_gnt = 0; imem_rvalid = 0; branch_flag = 0;
      @(negedge clk);
      rst = 0; branch_flag = 1; branch_target = 32'h40; imem_gnt = 1;
      @(negedge clk);
      branch_flag = 0; imem_gnt = 0;
      #1;
      chk("gntflag.drop_req",  {31'd0, imem_req}, 32'd0);
      chk("gntflag.drop_addr", imem_addr, 32'h40);
      imem_rvalid = 1; imem_rdata = DX;
      @(negedge clk);
      imem_rvalid = 0;
      #1;
      chk("gntflag.no_issue", {30'd0, issue}, 32'd0);
      chk("gntflag.req",      {31'd0, imem_req}, 32'd1);
      chk("gntflag.addr",     imem_addr, 32'h40);

      // Best case: request at t, offer valid at t+2, next request at t+3.
      imem_gnt = 1;
      @(negedge clk);
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 64'h00000013_00000093;
      @(negedge clk);
      imem_rvalid = 0;
      #1;
      chk("best.issue",    {30'd0, issue}, 32'd3);
      chk("best.in1_pc",   in1_pc, 32'h40);
      chk("best.in1_inst", in1_inst, 32'h93);
      chk("best.in2_inst", in2_inst, 32'h13);
      chk("best.in2_npc",  in2_npc, 32'h48);
      n = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         #1;
         if (imem_req) begin
            n = c;
            break;
         end
      end
      if (n == 0) begin
         checks++;
         $display("FAIL best.next_req: no request within 8 cycles, expected 1");
      end else begin
         chk("best.next_req_cycles", n, 32'd1);
         chk("best.next_addr", imem_addr, 32'h48);
         chk("best.issue_cleared", {30'd0, issue}, 32'd0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
